// File: rtl/free_list_pkg.sv
// Shared types and constants for the physical-register free list and its neighbours.
package free_list_pkg;

    localparam int N_PHY_REG = 64;
    localparam int N_ARC_REG = 32;
    localparam int N_FREE    = N_PHY_REG - N_ARC_REG;

    typedef logic                             bool;
    typedef logic [$clog2(N_PHY_REG)-1:0]     phy_reg_t;
    typedef logic [$clog2(N_ARC_REG)-1:0]     arc_reg_t;
    typedef logic [$clog2(N_FREE + 1)-1:0]    free_cnt_t;

endpackage

// File: rtl/free_list_if.sv
// Retire-side bundle: per-slot valid plus the old physical tag each retiring
// instruction releases. Retire drives it as master, the free list listens as slave.
interface free_list_if
    import free_list_pkg::*;
#(
    parameter int WIDTH = 3
);

    logic [WIDTH-1:0] valid;
    phy_reg_t         phy_dst_old [WIDTH];

    modport master (output valid, output phy_dst_old);
    modport slave  (input  valid, input  phy_dst_old);

endinterface

// File: rtl/free_list_popcount_prefix.sv
// Per-slot exclusive prefix counts of a small bit vector, plus the total.
// Used to compact sparse slot requests into consecutive buffer offsets.
module popcount_prefix #(
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] prefix [WIDTH],
    output logic [CNT_W-1:0] total
);

    // Running sum: prefix[i] counts the set bits strictly below slot i.
    always_comb begin : g_sum
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = acc;
            acc       = acc + CNT_W'(vec[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags. Rename pops up to WIDTH tags
// per cycle from head; retire pushes released tags at tail. A flush rewinds
// head to the retire-side head so every speculatively issued tag is free again.
module free_list
    import free_list_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int N_PHY_REG = 64,
    parameter int N_ARC_REG = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] alloc_req,
    output logic [WIDTH-1:0] alloc_avail,
    output phy_reg_t         alloc_phy [WIDTH],
    free_list_if.slave       rt,
    output free_cnt_t        free_count
);

    localparam int ENTRIES = N_PHY_REG - N_ARC_REG;
    localparam int PTR_W   = $clog2(ENTRIES);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] slot_cnt_t;

    phy_reg_t  tag_buf [ENTRIES];
    ptr_t      head, rhead, tail;
    ptr_t      head_n, rhead_n, tail_n;
    free_cnt_t count, count_n;

    logic [WIDTH-1:0] free_vec;
    slot_cnt_t        k_prefix [WIDTH];
    slot_cnt_t        k_total;
    slot_cnt_t        a_prefix [WIDTH];
    slot_cnt_t        a_total;

    // Ring pointer advance; offset never exceeds WIDTH <= ENTRIES, so one
    // conditional subtract is enough even for non-power-of-two sizes.
    function automatic ptr_t ptr_add(ptr_t base, slot_cnt_t off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W + 1)'(off);
        if (sum >= (PTR_W + 1)'(ENTRIES))
            sum = sum - (PTR_W + 1)'(ENTRIES);
        return sum[PTR_W-1:0];
    endfunction

    // A retire slot frees a tag only when it is valid and had a destination.
    always_comb begin
        for (int i = 0; i < WIDTH; i++)
            free_vec[i] = rt.valid[i] && (rt.phy_dst_old[i] != '0);
    end

    popcount_prefix #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_free_cnt (
        .vec    (free_vec),
        .prefix (k_prefix),
        .total  (k_total)
    );

    popcount_prefix #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_alloc_cnt (
        .vec    (alloc_req),
        .prefix (a_prefix),
        .total  (a_total)
    );

    // Grant view: the next WIDTH tags from head, with availability per slot.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            alloc_avail[i] = (count > free_cnt_t'(i));
            alloc_phy[i]   = tag_buf[ptr_add(head, slot_cnt_t'(i))];
        end
        free_count = count;
    end

    // Pointer/count next state; a flush discards this cycle's allocation.
    always_comb begin
        tail_n  = ptr_add(tail, k_total);
        rhead_n = ptr_add(rhead, k_total);
        if (flush) begin
            head_n  = rhead_n;
            count_n = free_cnt_t'(ENTRIES);
        end else begin
            head_n  = ptr_add(head, a_total);
            count_n = count - free_cnt_t'(a_total) + free_cnt_t'(k_total);
        end
    end

    // State update; freed tags land at tail in slot order, readable next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                tag_buf[i] <= phy_reg_t'(N_ARC_REG + i);
            head  <= '0;
            rhead <= '0;
            tail  <= '0;
            count <= free_cnt_t'(ENTRIES);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (free_vec[i])
                    tag_buf[ptr_add(tail, k_prefix[i])] <= rt.phy_dst_old[i];
            end
            head  <= head_n;
            rhead <= rhead_n;
            tail  <= tail_n;
            count <= count_n;
        end
    end

    // Simulation-only sanity: legal requests, bounded occupancy, sane freed tags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ((alloc_req & ~alloc_avail) == '0);
            for (int i = 0; i < WIDTH; i++) begin
                if (alloc_req[i])
                    assert (a_prefix[i] == slot_cnt_t'(i));
                if (free_vec[i])
                    assert (rt.phy_dst_old[i] != '0 &&
                            int'(rt.phy_dst_old[i]) < N_PHY_REG);
            end
            if (!flush) begin
                assert (int'(count) + int'(k_total) >= int'(a_total));
                assert (int'(count) + int'(k_total) - int'(a_total) <= ENTRIES);
            end
        end
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular buffer of free physical register tags.
- Sits between rename/dispatch (consumer of tags) and retire (producer of freed tags via the retire interface's fl modport).
- Hands out up to WIDTH tags per cycle in order and reclaims phy_dst_old of retiring instructions.
- Supports full-pipeline flush by rolling the allocation head back to a retire-side shadow head.

Parameters:
- WIDTH, 3, dispatch/retire slots per cycle; must match the retire interface WIDTH.
- N_PHY_REG, 64, total physical registers.
- N_ARC_REG, 32, architectural registers.
- Derived: N_FREE = N_PHY_REG - N_ARC_REG (32), number of buffer entries.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash all in-flight instructions; restore head.
- alloc_req  input  WIDTH  slot i requests one tag; requests are packed (req[i] implies req[i-1]).
- alloc_avail  output  WIDTH  avail[i] = (count > i).
- alloc_phy  output  WIDTH x phy_reg_t  tag for slot i.
- rt  input  retire.fl  valid[WIDTH], phy_dst_old[WIDTH].
- free_count  output  $clog2(N_FREE+1)  current number of free entries.

Behaviour:
- Storage and state:
  - buf[N_FREE] of phy_reg_t.
  - head, rhead (retire head), tail: pointers of $clog2(N_FREE) bits, wrapping modulo N_FREE.
  - count register.
- Reset (synchronous):
  - buf[i] = N_ARC_REG + i; head = rhead = tail = 0; count = N_FREE.
  - Outputs after reset: alloc_avail = all ones (when N_FREE >= WIDTH); alloc_phy[i] = 32+i; free_count = 32.
  - Reset overrides flush and all traffic.
- Tag 0 is the hardwired x0 mapping. It is never in the buffer.
- A retire slot with phy_dst_old == 0 marks an instruction without a destination. For such a slot: no free, no rhead advance.
- Allocation (combinational outputs):
  - alloc_phy[i] = buf[(head+i) mod N_FREE]. Packed requests make the prefix index equal i.
  - Registered effect: head += popcount(alloc_req); count -= popcount(alloc_req).
  - alloc_req[i] with !alloc_avail[i] is illegal (assertion). The block's behaviour is then undefined.
- Free (retire):
  - Let k = number of slots with rt.valid[i] && phy_dst_old[i] != 0.
  - Those tags are written to buf[tail], buf[tail+1], … in slot order; tail += k; rhead += k; count += k.
  - Freed tags become allocatable the next cycle, never the same cycle (no bypass).
- Simultaneous alloc and free: count_next = count - a + k. Both pointer updates happen in the same cycle.
- Flush:
  - Retirement presented in the same cycle is still processed.
  - Allocation in the flush cycle is ignored.
  - head_next = rhead_next; count_next = N_FREE.
  - Invariant: (tail - rhead) mod N_FREE plus the architectural mappings always accounts for all tags, so every non-architectural tag is free after a flush.
- Wrap-around: all pointer and slot-index arithmetic is modulo N_FREE. Per-slot write addresses are computed as (tail + prefix_k) mod N_FREE.
- Assertions:
  - count never exceeds N_FREE and never underflows.
  - A freed tag is never 0 and never ≥ N_PHY_REG.
- Latency: allocation outputs are valid in the same cycle. State updates are one cycle.

Decomposition:
- Shared package / defs.svh:
  - bool, phy_reg_t, arc_reg_t.
  - N_PHY_REG and N_ARC_REG constants.
  - Add a shared free_cnt_t typedef.
- Sub-module popcount_prefix (WIDTH-bit vector → per-slot prefix counts plus total). It is used for both the retire write-index compaction and the allocation count; the rename map table can reuse it.

Test Plan:
- Reset -> free_count=32, alloc_phy={32,33,34}, alloc_avail=3'b111.
- alloc_req=3'b111 for 10 cycles, then 3'b011 -> last grants 62,63; free_count=0, alloc_avail=000.
- Same cycle: alloc_req=3'b001 and retire valid=111 with phy_dst_old={5,0,7} -> count changes by -1+2; next cycle tags 5 and 7 appear after the existing entries in order. Tag 0 is not freed.
- Wrap: allocate 31 tags, retire 31 old tags, allocate 3 -> head crosses index 31→0; alloc_phy matches the buffer in tail order with no duplicates.
- Flush with 20 tags allocated and 4 retiring (valid, non-zero old tags) in the same cycle -> next cycle free_count=32 and head==rhead; the in-flight tags are re-issued in the original order.
- Reset asserted mid-burst with alloc_req and retire active -> next cycle state equals the post-reset values of the first scenario.
